// File: rtl/cmp_flags_unit.sv
// Registered compare unit: subtracts In2 from In1 and captures ARM-style {N,Z,C,V}
// flags one clock later, or reloads the incoming architectural flags when disabled.
module cmp_flags_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       Flag,
  input  logic             En,
  output logic [3:0]       New_Flag
);

  logic [3:0] flag_d;
  logic [3:0] flag_q;

  // Subtraction done as In1 + ~In2 + 1 so the carry out is the "no borrow" flag.
  function automatic logic [3:0] sub_flags(input logic signed [WIDTH-1:0] a,
                                           input logic signed [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    logic           n, z, c, v;
    sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    n   = sum[WIDTH-1];
    z   = (sum[WIDTH-1:0] == '0);
    c   = sum[WIDTH];
    v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return {n, z, c, v};
  endfunction

  always_comb begin
    flag_d = Flag;
    if (En) begin
      flag_d = sub_flags($signed(In1), $signed(In2));
    end
  end

  // Stage boundary: operands sampled here, flags visible one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 4'b0000;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign New_Flag = flag_q;

endmodule

// File: tb/tb_cmp_flags_unit.sv
// Self-checking bench for cmp_flags_unit: directed corner cases plus randomized
// compares against an arithmetic reference model of the flag rules.
module tb_cmp_flags_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [3:0]       Flag;
  logic             En;
  logic [3:0]       New_Flag;

  int tests;
  int fails;

  cmp_flags_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .In1      (In1),
    .In2      (In2),
    .Flag     (Flag),
    .En       (En),
    .New_Flag (New_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flags from exact integer arithmetic, not from the adder structure.
  function automatic logic [3:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint     sa, sb, d;
    logic [WIDTH-1:0] t;
    logic n, z, c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d  = sa - sb;
    t  = a - b;
    n  = t[WIDTH-1];
    z  = (a == b);
    c  = (a >= b);
    v  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    return {n, z, c, v};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, then compare the registered flags.
  task automatic step(input string tag, input logic en, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [3:0] f, input logic [3:0] exp);
    En = en; In1 = a; In2 = b; Flag = f;
    @(posedge clk);
    #1;
    check(tag, New_Flag, exp);
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [WIDTH-1:0] a, b;
    logic [3:0]       f, exp, prev;
    logic             en;
    tests = 0;
    fails = 0;
    rst = 1'b1; En = 1'b0; In1 = '0; In2 = '0; Flag = 4'b0000;
    #1;
    check("reset_at_start", New_Flag, 4'b0000);
    @(posedge clk); #1;
    check("reset_holds_over_edge", New_Flag, 4'b0000);
    rst = 1'b0;

    // Load 1111, then assert reset between edges.
    step("load_ones", 1'b0, '0, '0, 4'b1111, 4'b1111);
    #2 rst = 1'b1;
    #1;
    check("async_reset_clears", New_Flag, 4'b0000);
    @(posedge clk); #1;
    check("reset_held_high", New_Flag, 4'b0000);
    rst = 1'b0;
    step("eq_after_reset", 1'b1, 32'd5, 32'd5, 4'b0000, 4'b0110);

    step("signed_lt", 1'b1, 32'd3, 32'd5, 4'b0000, 4'b1000);
    step("neg1_vs_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 4'b1010);
    step("ovf_pos", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 4'b1001);
    step("ovf_neg", 1'b1, 32'h8000_0000, 32'd1, 4'b0000, 4'b0011);
    step("passthru", 1'b0, 32'd0, 32'd7, 4'b0101, 4'b0101);
    step("en_after_pass", 1'b1, 32'd0, 32'd7, 4'b0101, 4'b1000);
    step("b2b_0", 1'b1, 32'd10, 32'd10, 4'b0000, 4'b0110);
    step("b2b_1", 1'b1, 32'd2, 32'd9, 4'b0000, 4'b1000);
    step("b2b_2", 1'b1, 32'd9, 32'd2, 4'b0000, 4'b0010);
    step("sub_zero", 1'b1, 32'h8000_0000, 32'd0, 4'b0000, 4'b1010);
    step("minneg_eq", 1'b1, 32'h8000_0000, 32'h8000_0000, 4'b0000, 4'b0110);
    step("zero_minus_minneg", 1'b1, 32'd0, 32'h8000_0000, 4'b0000, 4'b1001);

    // Changing inputs between edges must not disturb the registered output.
    In1 = 32'd1; In2 = 32'd2; Flag = 4'b1111; En = 1'b0;
    #2;
    check("no_comb_path", New_Flag, 4'b1001);

    // Reset mid-cycle discards the pending capture.
    In1 = 32'd3; In2 = 32'd5; En = 1'b1;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    check("midcycle_reset", New_Flag, 4'b0000);
    @(posedge clk); #1;
    check("capture_after_midreset", New_Flag, 4'b1000);

    // Randomized compares, including decoder relations against native compares.
    for (int i = 0; i < 400; i++) begin
      a  = pick_operand();
      b  = ($urandom_range(0, 9) == 0) ? a : pick_operand();
      f  = 4'($urandom());
      en = ($urandom_range(0, 3) != 0);
      exp = en ? ref_flags(a, b) : f;
      step("random", en, a, b, f, exp);
      if (en) begin
        prev = New_Flag;
        check_bit("rel_lt", prev[3] != prev[0], $signed(a) < $signed(b));
        check_bit("rel_hi", prev[1] && !prev[2], a > b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmp_flags_unit.md
Name: cmp_flags_unit

Overview:
- Registered compare unit: computes In1 − In2 and produces ARM-style condition flags {N,Z,C,V}.
- Sits in the ALU conditional-execution path. Its New_Flag output feeds the condition decoder, which derives EQ/GT/LT/GE/LE/HI/LO/HS.
- When disabled, the flag register loads the incoming architectural flags unchanged.

Parameters:
- WIDTH, 32, operand width in bits (two's-complement operands).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears the flag register.
- In1  input  WIDTH  minuend, signed.
- In2  input  WIDTH  subtrahend, signed.
- Flag  input  4  current architectural flags, bit order [3]=N [2]=Z [1]=C [0]=V.
- En  input  1  1 = compare In1 against In2; 0 = pass Flag through.
- New_Flag  output  4  registered flags, bit order [3]=N [2]=Z [1]=C [0]=V.

Behaviour:
- Reset: when rst is asserted, New_Flag = 4'b0000 immediately, independent of clk. It holds 0000 while rst is high. The first update happens on the first clk rising edge after rst deasserts.
- Datapath: compute diff = In1 + ~In2 + 1 at WIDTH+1 bits. Let cout be bit WIDTH of that sum.
  - N = diff[WIDTH-1].
  - Z = 1 when diff[WIDTH-1:0] == 0.
  - C = cout. C is the "no borrow" flag: C = 1 iff In1 ≥ In2 as unsigned values.
  - V = (In1[MSB] != In2[MSB]) && (diff[MSB] != In1[MSB]). This is signed overflow of the subtraction.
- Register update on each clk rising edge, with rst low:
  - En = 1: New_Flag ← {N,Z,C,V} computed from the current In1/In2.
  - En = 0: New_Flag ← Flag.
- Latency: exactly 1 clock from sampled inputs to New_Flag. There is no handshake, and a new compare can be issued every cycle.
- Operands are sampled only at the clock edge. Input changes between edges have no effect on New_Flag.
- Outputs are combinationally independent of In1, In2, Flag and En. Only rst acts asynchronously.
- Boundary cases:
  - In1 == In2: Z=1, C=1, N=0, V=0.
  - In2 == 0: C=1, V=0.
  - Operands equal to the most-negative value are handled per the formulas above.
  - Wrap-around in diff is expected and is reported through C and V.
- Reset during operation: an asynchronous rst asserted mid-cycle forces New_Flag to 0000 at once. Any pending capture is discarded.
- All four flag bits are driven every cycle. No X is propagated when inputs are known.
- Flag relations the downstream decoder relies on:
  - EQ ⇔ Z.
  - LT ⇔ N≠V.
  - GE ⇔ N==V.
  - HS ⇔ C.
  - LO ⇔ !C.
  - HI ⇔ C && !Z.

Test Plan:
- Reset: assert rst with New_Flag previously 1111. New_Flag = 0000 before the next clk edge. Deassert rst, En=1, In1=5, In2=5; after 1 edge New_Flag = 0110.
- Signed less-than: En=1, In1=3, In2=5. After 1 edge New_Flag = 1000 (N=1, Z=0, C=0, V=0).
- Unsigned vs signed: En=1, In1=-1 (0xFFFFFFFF), In2=1. New_Flag = 1010 (N=1, C=1). This confirms LT is signed-true while HS is unsigned-true.
- Overflows:
  - In1=0x7FFFFFFF, In2=0xFFFFFFFF: New_Flag = 1001.
  - In1=0x80000000, In2=1: New_Flag = 0011.
- Pass-through: En=0, Flag=0101, In1=0, In2=7. After 1 edge New_Flag = 0101. Then En=1 on the next cycle with the same In1/In2 gives New_Flag = 1000.
- Back-to-back: issue (10,10), (2,9), (9,2) on consecutive cycles. New_Flag sequence is 0110, 1000, 0010, each one cycle after its operands.
